// File: rtl/vc_pop_scheduler_if.sv
// Signal bundle between the VC pop scheduler and its VC FIFOs / destinations.
// The master side is the scheduler; the slave side is the surrounding FIFO logic.
interface vc_pop_scheduler_if #(
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2
);
    localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC-1:0]   vc_empty;
    logic [NUM_DEST-1:0] pause_d;
    logic [NUM_VC-1:0]   pop_vc;
    logic [NUM_VC-1:0]   valid_vc;
    logic                paused;
    logic [PTR_W-1:0]    rr_ptr;

    modport master (
        input  vc_empty,
        input  pause_d,
        output pop_vc,
        output valid_vc,
        output paused,
        output rr_ptr
    );

    modport slave (
        output vc_empty,
        output pause_d,
        input  pop_vc,
        input  valid_vc,
        input  paused,
        input  rr_ptr
    );
endinterface

// File: rtl/vc_pop_scheduler.sv
// Pop controller for NUM_VC virtual-channel FIFOs: parallel or round-robin popping,
// gated by destination pause plus a programmable resume holdoff.
module vc_pop_scheduler #(
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int RESUME_DLY = 0,
    parameter int CNT_W      = 4,
    parameter int RR_MODE    = 0
) (
    input  logic                clk,
    input  logic                reset_L,
    vc_pop_scheduler_if.master  bus
);
    localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(RESUME_DLY);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   NUM_VC_W = (PTR_W+1)'(NUM_VC);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // Adds an offset to a VC index, wrapping modulo NUM_VC (works for non-power-of-2 counts).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W:0]   off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NUM_VC_W) begin
            sum = sum - NUM_VC_W;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Returns {found, index} of the first requesting VC at or above ptr, with wrap.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_VC-1:0] req,
                                               input logic [PTR_W-1:0]  ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] idx;
        res = {(PTR_W+1){1'b0}};
        // Scan from the farthest offset down so the nearest requester wins.
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            idx = wrap_add(ptr, (PTR_W+1)'(i));
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic                any_pause_s;
    logic                pop_en_s;
    logic [CNT_W-1:0]    hcnt_r;
    logic [CNT_W-1:0]    hcnt_nxt_s;
    state_e              state_r;
    state_e              state_nxt_s;
    logic [NUM_VC-1:0]   pop_s;
    logic [PTR_W:0]      pick_s;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    rr_ptr_nxt_s;
    logic [NUM_VC-1:0]   valid_r;
    logic                paused_r;

    assign any_pause_s = |bus.pause_d;
    // Pause blocks combinationally; the holdoff counter covers the resume latency.
    assign pop_en_s    = reset_L & ~any_pause_s & (hcnt_r == CNT_ZERO);
    assign pick_s      = rr_pick(~bus.vc_empty, rr_ptr_r);

    // Holdoff counter next value: reload on pause, otherwise count down to zero.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        if (any_pause_s) begin
            hcnt_nxt_s = DLY_C;
        end else if (hcnt_r != CNT_ZERO) begin
            hcnt_nxt_s = hcnt_r - CNT_ONE;
        end else begin
            hcnt_nxt_s = CNT_ZERO;
        end
    end

    // Pop strobe generation and round-robin pointer advance.
    always_comb begin
        pop_s        = {NUM_VC{1'b0}};
        rr_ptr_nxt_s = rr_ptr_r;
        if (RR_MODE == 0) begin
            rr_ptr_nxt_s = PTR_ZERO;
            if (pop_en_s) begin
                pop_s = ~bus.vc_empty;
            end else begin
                pop_s = {NUM_VC{1'b0}};
            end
        end else if (pop_en_s && pick_s[PTR_W]) begin
            pop_s[pick_s[PTR_W-1:0]] = 1'b1;
            rr_ptr_nxt_s = wrap_add(pick_s[PTR_W-1:0], {{PTR_W{1'b0}}, 1'b1});
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Status FSM next-state; it only shapes the paused flag, never the pop path.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (any_pause_s) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (any_pause_s) begin
                    state_nxt_s = ST_PAUSED;
                end else if (RESUME_DLY == 0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (any_pause_s) begin
                    state_nxt_s = ST_PAUSED;
                end else if (hcnt_nxt_s == CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Holdoff counter register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            hcnt_r <= CNT_ZERO;
        end else begin
            hcnt_r <= hcnt_nxt_s;
        end
    end

    // FSM state and registered paused flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r  <= ST_RUN;
            paused_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            paused_r <= (state_nxt_s != ST_RUN);
        end
    end

    // Registered per-VC valid and round-robin pointer.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_r  <= {NUM_VC{1'b0}};
            rr_ptr_r <= PTR_ZERO;
        end else begin
            valid_r  <= pop_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign bus.pop_vc   = pop_s;
    assign bus.valid_vc = valid_r;
    assign bus.paused   = paused_r;
    assign bus.rr_ptr   = rr_ptr_r;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: three configurations checked cycle by cycle against
// a pause-history reference model, plus directed scenarios and random traffic.
module tb_vc_pop_scheduler;
    localparam int NV0 = 2, RR0 = 0, DL0 = 0;
    localparam int NV1 = 2, RR1 = 0, DL1 = 3;
    localparam int NV2 = 4, RR2 = 1, DL2 = 2;

    int nv  [3] = '{NV0, NV1, NV2};
    int rrm [3] = '{RR0, RR1, RR2};
    int dly [3] = '{DL0, DL1, DL2};

    logic       clk;
    logic       reset_L;
    logic [3:0] ve [3];
    logic [1:0] pd [3];

    logic [3:0] o_pop   [3];
    logic [3:0] o_valid [3];
    logic       o_paused[3];
    logic [1:0] o_ptr   [3];

    // Reference model: cycles of quiet since last pause, previous pops, pointer.
    int         m_quiet [3];
    logic [3:0] m_valid [3];
    logic       m_paused[3];
    int         m_ptr   [3];
    logic [3:0] e_pop   [3];

    int n_pass;
    int n_total;

    vc_pop_scheduler_if #(.NUM_VC(NV0), .NUM_DEST(2)) if0 ();
    vc_pop_scheduler_if #(.NUM_VC(NV1), .NUM_DEST(2)) if1 ();
    vc_pop_scheduler_if #(.NUM_VC(NV2), .NUM_DEST(2)) if2 ();

    vc_pop_scheduler #(.NUM_VC(NV0), .NUM_DEST(2), .RESUME_DLY(DL0), .CNT_W(4), .RR_MODE(RR0))
        u0 (.clk(clk), .reset_L(reset_L), .bus(if0.master));
    vc_pop_scheduler #(.NUM_VC(NV1), .NUM_DEST(2), .RESUME_DLY(DL1), .CNT_W(4), .RR_MODE(RR1))
        u1 (.clk(clk), .reset_L(reset_L), .bus(if1.master));
    vc_pop_scheduler #(.NUM_VC(NV2), .NUM_DEST(2), .RESUME_DLY(DL2), .CNT_W(4), .RR_MODE(RR2))
        u2 (.clk(clk), .reset_L(reset_L), .bus(if2.master));

    assign if0.vc_empty = ve[0][1:0];
    assign if1.vc_empty = ve[1][1:0];
    assign if2.vc_empty = ve[2];
    assign if0.pause_d  = pd[0];
    assign if1.pause_d  = pd[1];
    assign if2.pause_d  = pd[2];

    assign o_pop[0]    = {2'b00, if0.pop_vc};
    assign o_pop[1]    = {2'b00, if1.pop_vc};
    assign o_pop[2]    = if2.pop_vc;
    assign o_valid[0]  = {2'b00, if0.valid_vc};
    assign o_valid[1]  = {2'b00, if1.valid_vc};
    assign o_valid[2]  = if2.valid_vc;
    assign o_paused[0] = if0.paused;
    assign o_paused[1] = if1.paused;
    assign o_paused[2] = if2.paused;
    assign o_ptr[0]    = {1'b0, if0.rr_ptr};
    assign o_ptr[1]    = {1'b0, if1.rr_ptr};
    assign o_ptr[2]    = if2.rr_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            m_quiet[k]  = 1000;
            m_valid[k]  = 4'b0000;
            m_paused[k] = 1'b0;
            m_ptr[k]    = 0;
        end
    endtask

    function automatic logic [3:0] model_pop(input int k);
        logic [3:0] res;
        logic [3:0] mask;
        logic       found;
        int         idx;
        res   = 4'b0000;
        found = 1'b0;
        mask  = (nv[k] == 4) ? 4'b1111 : 4'b0011;
        if (!reset_L || pd[k] != 2'b00 || m_quiet[k] < dly[k]) return 4'b0000;
        if (rrm[k] == 0) return ~ve[k] & mask;
        for (int i = 0; i < nv[k]; i++) begin
            idx = (m_ptr[k] + i) % nv[k];
            if (!found && !ve[k][idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    // Let combinational outputs settle, then compare every output of every instance.
    task automatic settle();
        #2;
        for (int k = 0; k < 3; k++) begin
            e_pop[k] = model_pop(k);
            chk($sformatf("pop%0d", k),    32'(o_pop[k]),    32'(e_pop[k]));
            chk($sformatf("valid%0d", k),  32'(o_valid[k]),  32'(m_valid[k]));
            chk($sformatf("paused%0d", k), 32'(o_paused[k]), 32'(m_paused[k]));
            chk($sformatf("rrptr%0d", k),  32'(o_ptr[k]),    32'(m_ptr[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset_L) begin
                m_quiet[k]  = 1000;
                m_valid[k]  = 4'b0000;
                m_paused[k] = 1'b0;
                m_ptr[k]    = 0;
            end else begin
                m_valid[k]  = e_pop[k];
                m_paused[k] = (pd[k] != 2'b00) || (m_quiet[k] + 1 < dly[k]);
                if (rrm[k] == 1) begin
                    for (int i = 0; i < nv[k]; i++)
                        if (e_pop[k][i]) m_ptr[k] = (i + 1) % nv[k];
                end
                m_quiet[k] = (pd[k] != 2'b00) ? 0 : ((m_quiet[k] >= 1000) ? 1000 : m_quiet[k] + 1);
            end
        end
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_L = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ve[k] = 4'b1111;
            pd[k] = 2'b00;
        end
        reset_model();

        settle();
        chk("rst valid", 32'(o_valid[0]), 32'd0);
        chk("rst paused", 32'(o_paused[1]), 32'd0);
        tick();
        settle();
        tick();

        // Release reset with everything non-empty: pops in the very first cycle.
        reset_L = 1'b1;
        ve[0] = 4'b0000; ve[1] = 4'b0000; ve[2] = 4'b0000;
        settle();
        chk("par pop all", 32'(o_pop[0]), 32'h3);
        chk("rr seq0", 32'(o_pop[2]), 32'h1);
        tick();
        settle();
        chk("par valid", 32'(o_valid[0]), 32'h3);
        chk("rr seq1", 32'(o_pop[2]), 32'h2);
        tick();
        ve[0] = 4'b0010;
        settle();
        chk("par pop part", 32'(o_pop[0]), 32'h1);
        chk("rr seq2", 32'(o_pop[2]), 32'h4);
        tick();
        settle();
        chk("rr seq3", 32'(o_pop[2]), 32'h8);
        tick();
        settle();
        chk("rr seq4", 32'(o_pop[2]), 32'h1);
        tick();
        ve[2] = 4'b0010;
        settle();
        chk("rr ptr pre", 32'(o_ptr[2]), 32'd1);
        chk("rr skip", 32'(o_pop[2]), 32'h4);
        tick();
        settle();
        chk("rr ptr post", 32'(o_ptr[2]), 32'd3);
        tick();

        // Three-cycle pause on destination 1 with zero resume delay.
        ve[0] = 4'b0000;
        pd[0] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("pause pop", 32'(o_pop[0]), 32'h0);
            if (i > 0) chk("pause flag", 32'(o_paused[0]), 32'd1);
            tick();
        end
        pd[0] = 2'b00;
        settle();
        chk("resume pop", 32'(o_pop[0]), 32'h3);
        chk("resume flag lag", 32'(o_paused[0]), 32'd1);
        tick();
        settle();
        chk("resume flag clr", 32'(o_paused[0]), 32'd0);
        tick();

        // Resume delay of 3 after a two-cycle pause.
        ve[1] = 4'b0000;
        pd[1] = 2'b01;
        settle(); tick();
        settle(); tick();
        pd[1] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("holdoff pop", 32'(o_pop[1]), 32'h0);
            chk("holdoff flag", 32'(o_paused[1]), 32'd1);
            tick();
        end
        settle();
        chk("holdoff done pop", 32'(o_pop[1]), 32'h3);
        chk("holdoff done flag", 32'(o_paused[1]), 32'd0);
        tick();

        // Pause re-asserted during holdoff restarts the full delay.
        pd[1] = 2'b01;
        settle(); tick();
        settle(); tick();
        pd[1] = 2'b00;
        settle(); tick();
        pd[1] = 2'b10;
        settle(); tick();
        pd[1] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("reload pop", 32'(o_pop[1]), 32'h0);
            tick();
        end
        settle();
        chk("reload done pop", 32'(o_pop[1]), 32'h3);
        tick();

        // Asynchronous reset while instance 1 is in holdoff and instance 0 is streaming.
        pd[1] = 2'b01;
        settle(); tick();
        pd[1] = 2'b00;
        settle();
        chk("pre-rst valid", 32'(o_valid[0]), 32'h3);
        chk("pre-rst paused", 32'(o_paused[1]), 32'd1);
        reset_L = 1'b0;
        reset_model();
        #1;
        chk("async valid", 32'(o_valid[0]), 32'h0);
        chk("async paused", 32'(o_paused[1]), 32'd0);
        chk("async rrptr", 32'(o_ptr[2]), 32'd0);
        chk("async pop", 32'(o_pop[0]), 32'h0);
        settle();
        tick();
        reset_L = 1'b1;
        settle();
        chk("post-rst pop0", 32'(o_pop[0]), 32'h3);
        chk("post-rst pop1", 32'(o_pop[1]), 32'h3);
        tick();

        // Random traffic with occasional pauses and periodic resets.
        for (int c = 0; c < 400; c++) begin
            reset_L = (c % 128 == 127) ? 1'b0 : 1'b1;
            if (!reset_L) reset_model();
            for (int k = 0; k < 3; k++) begin
                ve[k] = 4'($urandom);
                pd[k] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
